sd_blk_responder: RTL and testbench

- Responder (host) end of the MiSTer SD block-level interface used by the four-drive floppy controller.
- Serves sd_rd/sd_wr requests from up to four drive channels by moving 512-byte blocks between a byte-wide backing memory and the initiator's dual-port sector buffer.
- Drives sd_ack, sd_buff_addr, sd_buff_dout and sd_buff_wr, and samples sd_buff_din.
- Used as a RAM-disk server, and as the bench model for floppy controller verification.

---
 rtl/sd_blk_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_sd_blk_responder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_blk_responder.sv
// ---------------------------------------------------------------------------
// sd_blk_responder
//
// Host (responder) end of the MiSTer SD block interface for the four-drive
// floppy controller. Moves 512-byte blocks between a byte-wide backing memory
// and the requesting drive's dual-port sector buffer. Serves as a RAM-disk
// server and as the bench model for floppy controller verification.
//
// Ports
//   CLK, RESET_N     rising-edge clock, asynchronous active-low reset
//   sd_lba[4]        requested block number per drive
//   sd_rd, sd_wr     per-drive read / write request levels, held until ack
//   sd_ack           one-hot (or zero) transfer-in-progress per drive
//   sd_buff_addr     byte offset within the block
//   sd_buff_dout     read data towards the initiator buffer
//   sd_buff_wr       one-cycle write strobe into the initiator buffer
//   sd_buff_din[4]   initiator buffer read data, used for writes
//   mem_*            backing memory request/handshake, address is
//                    {drive, lba[10:0], offset[8:0]}
//   busy             FSM not idle
//   oob              sticky: some request had lba >= MAX_LBA
// ---------------------------------------------------------------------------
module sd_blk_responder #(
    parameter int MAX_LBA = 2048,
    parameter int MEM_AW  = 22,
    parameter int DIN_LAT = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [31:0]       sd_lba [4],
    input  logic [3:0]        sd_rd,
    input  logic [3:0]        sd_wr,
    output logic [3:0]        sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    output logic              sd_buff_wr,
    input  logic [7:0]        sd_buff_din [4],
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              oob
);

    localparam int LBA_W  = $clog2(MAX_LBA);
    localparam int WAIT_W = (DIN_LAT > 1) ? $clog2(DIN_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        RD_FETCH,
        RD_PUSH,
        WR_ADDR,
        WR_WAIT,
        WR_STORE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        pending;
    logic [1:0]        ptr;
    logic [1:0]        grant;
    logic [1:0]        pick;
    logic              pick_valid;
    logic [LBA_W-1:0]  lba;
    logic              is_read;
    logic              out_range;
    logic [8:0]        offset;
    logic [7:0]        data;
    logic [WAIT_W-1:0] wait_cnt;
    logic              last_byte;
    logic              byte_done;

    assign pending   = sd_rd | sd_wr;
    assign last_byte = (offset == 9'd511);

    // An out-of-range transfer never touches memory, so every byte
    // completes in a single cycle.
    assign byte_done = out_range || mem_ready;

    assign sd_buff_addr = offset;
    assign sd_buff_dout = data;
    assign mem_addr     = MEM_AW'({grant, lba, offset});

    // Round-robin pick: scanning from the farthest distance down to zero
    // leaves the nearest pending drive at or after ptr as the winner.
    always_comb begin
        pick       = ptr;
        pick_valid = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[ptr + 2'(i)]) begin
                pick       = ptr + 2'(i);
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sd_ack     = 4'b0000;
        sd_buff_wr = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                sd_ack     = 4'b0001 << grant;
                state_next = is_read ? RD_FETCH : WR_ADDR;
            end
            RD_FETCH: begin
                sd_ack = 4'b0001 << grant;
                mem_rd = !out_range;
                if (byte_done) begin
                    state_next = RD_PUSH;
                end
            end
            RD_PUSH: begin
                sd_ack     = 4'b0001 << grant;
                sd_buff_wr = 1'b1;
                state_next = last_byte ? DONE : RD_FETCH;
            end
            WR_ADDR: begin
                sd_ack     = 4'b0001 << grant;
                state_next = (DIN_LAT == 0) ? WR_STORE : WR_WAIT;
            end
            WR_WAIT: begin
                sd_ack = 4'b0001 << grant;
                if (wait_cnt == WAIT_W'(DIN_LAT - 1)) begin
                    state_next = WR_STORE;
                end
            end
            WR_STORE: begin
                sd_ack = 4'b0001 << grant;
                mem_wr = !out_range;
                if (byte_done) begin
                    state_next = last_byte ? DONE : WR_ADDR;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Transfer context and byte datapath. Request inputs are only looked at
    // in IDLE, so changes during a transfer have no effect.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr       <= 2'd0;
            grant     <= 2'd0;
            lba       <= '0;
            is_read   <= 1'b0;
            out_range <= 1'b0;
            offset    <= 9'd0;
            data      <= 8'd0;
            wait_cnt  <= '0;
            mem_wdata <= 8'd0;
            oob       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant     <= pick;
                        ptr       <= pick + 2'd1;
                        lba       <= sd_lba[pick][LBA_W-1:0];
                        is_read   <= sd_rd[pick];
                        out_range <= (sd_lba[pick] >= 32'(MAX_LBA));
                        offset    <= 9'd0;
                        if (sd_lba[pick] >= 32'(MAX_LBA)) begin
                            oob <= 1'b1;
                        end
                    end
                end
                RD_FETCH: begin
                    if (out_range) begin
                        data <= 8'd0;
                    end else if (mem_ready) begin
                        data <= mem_rdata;
                    end
                end
                RD_PUSH: begin
                    if (!last_byte) begin
                        offset <= offset + 9'd1;
                    end
                end
                WR_ADDR: begin
                    wait_cnt <= '0;
                    if (DIN_LAT == 0) begin
                        mem_wdata <= sd_buff_din[grant];
                    end
                end
                WR_WAIT: begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                    // Buffer data for the current offset is valid in the
                    // last wait cycle; hold it stable for the memory write.
                    if (wait_cnt == WAIT_W'(DIN_LAT - 1)) begin
                        mem_wdata <= sd_buff_din[grant];
                    end
                end
                WR_STORE: begin
                    if (byte_done && !last_byte) begin
                        offset <= offset + 9'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_blk_responder.sv
// ---------------------------------------------------------------------------
// tb_sd_blk_responder
//
// Bench for sd_blk_responder: byte-wide memory model with programmable ready
// delay, an initiator sector buffer with one clock of read latency, and a
// scoreboard of expected read strobes.
// ---------------------------------------------------------------------------
module tb_sd_blk_responder;

    localparam int BUDGET = 6000;

    typedef struct {
        logic [8:0] addr;
        logic [7:0] data;
    } sb_item_t;

    typedef struct {
        int          drive;
        logic [31:0] lba;
        bit          is_read;
        int          delay;
        bit          exp_oob;
        int          exp_ops;
        logic [21:0] exp_base;
        int          max_cycles;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] sd_lba [4];
    logic [3:0]  sd_rd;
    logic [3:0]  sd_wr;
    logic [3:0]  sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din [4];
    logic [21:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        oob;

    int          checks = 0;
    int          errors = 0;
    int          strobes = 0;
    int          mem_rd_cycles = 0;
    int          mem_wr_cycles = 0;
    sb_item_t    sb_q[$];
    int          grant_q[$];

    int          mem_delay = 0;
    int          mem_cnt = 0;
    int          hs_count = 0;
    logic [7:0]  mem_store [logic [21:0]];
    logic [21:0] hs_log [int];
    logic [7:0]  buff_q;

    always #5 CLK = ~CLK;

    sd_blk_responder #(
        .MAX_LBA (2048),
        .MEM_AW  (22),
        .DIN_LAT (1)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .busy         (busy),
        .oob          (oob)
    );

    // Initiator sector buffers: registered read, each drive with its own
    // pattern so picking the wrong drive's data shows up. Drive 2 is ~addr.
    always @(posedge CLK) buff_q <= ~sd_buff_addr[7:0];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sd_buff_din[i] = buff_q ^ (8'(i ^ 2) << 6);
        end
    end

    // Backing memory: byte k of every block reads back as k[7:0].
    assign mem_rdata = mem_addr[7:0];
    assign mem_ready = (mem_delay == 0) ? 1'b1 :
                       ((mem_rd || mem_wr) && (mem_cnt == mem_delay));

    always @(posedge CLK) begin
        if ((mem_rd || mem_wr) && mem_ready) begin
            if (mem_wr) mem_store[mem_addr] = mem_wdata;
            hs_log[hs_count] = mem_addr;
            hs_count <= hs_count + 1;
            mem_cnt  <= 0;
        end else if (mem_rd || mem_wr) begin
            mem_cnt <= mem_cnt + 1;
        end else begin
            mem_cnt <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Pops one scoreboard entry per buffer strobe, checks ack one-hotness,
    // counts memory request cycles and logs the order of ack grants.
    task automatic monitorLoop();
        logic [3:0] prev_ack = 4'b0000;
        sb_item_t   e;
        forever begin
            @(negedge CLK);
            if (sd_buff_wr) begin
                strobes++;
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_strobe", 32'(sd_buff_wr), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("strobe_addr", 32'(sd_buff_addr), 32'(e.addr));
                    checkOutput("strobe_data", 32'(sd_buff_dout), 32'(e.data));
                end
            end
            if (sd_ack != 4'b0000) checkOutput("ack_onehot", 32'($onehot(sd_ack)), 32'd1);
            if (mem_rd) mem_rd_cycles++;
            if (mem_wr) mem_wr_cycles++;
            for (int i = 0; i < 4; i++) begin
                if (sd_ack[i] && !prev_ack[i]) grant_q.push_back(i);
            end
            prev_ack = sd_ack;
        end
    endtask

    task automatic pushRead(input bit zeros);
        for (int k = 0; k < 512; k++) begin
            sb_q.push_back('{addr: 9'(k), data: zeros ? 8'h00 : 8'(k)});
        end
    endtask

    task automatic waitAck(input int drive, input bit level, input string name, inout int cycles);
        int start = cycles;
        do begin
            @(negedge CLK);
            cycles++;
        end while ((sd_ack[drive] != level) && (cycles - start < BUDGET));
        checkOutput(name, 32'(sd_ack[drive]), 32'(level));
    endtask

    task automatic applyStimulus(input int drive, input logic [31:0] lba, input bit rd, input bit wr,
                                 output int ack_wait, output int total);
        int cycles = 0;
        @(posedge CLK);
        #1;
        sd_lba[drive] = lba;
        sd_rd[drive]  = rd;
        sd_wr[drive]  = wr;
        waitAck(drive, 1'b1, "ack_rise", cycles);
        ack_wait = cycles;
        checkOutput("busy_active", 32'(busy), 32'd1);
        sd_rd[drive] = 1'b0;
        sd_wr[drive] = 1'b0;
        waitAck(drive, 1'b0, "ack_fall", cycles);
        total = cycles;
        @(negedge CLK);
        checkOutput("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic checkBlockWrite(input int drive, input logic [21:0] base);
        logic [21:0] a;
        logic [7:0]  exp;
        for (int k = 0; k < 512; k++) begin
            a   = base + 22'(k);
            exp = ~8'(k) ^ (8'(drive ^ 2) << 6);
            checkOutput("wr_data", mem_store.exists(a) ? 32'(mem_store[a]) : 32'hFFFF_FFFF, 32'(exp));
        end
    endtask

    initial begin
        vec_t vecs [5];
        int   ops0, rd0, wr0, ack_wait, total, s0, cyc;
        int   aw3, t3, aw1, t1;

        RESET_N = 1'b0;
        sd_rd   = 4'b0000;
        sd_wr   = 4'b0000;
        for (int i = 0; i < 4; i++) sd_lba[i] = 32'd0;

        vecs[0] = '{0, 32'd5,           1'b1, 0, 1'b0, 512, 22'h000A00, 1030};
        vecs[1] = '{2, 32'h7FF,         1'b0, 3, 1'b0, 512, 22'h2FFE00, 3200};
        vecs[2] = '{3, 32'h7FF,         1'b1, 0, 1'b0, 512, 22'h3FFE00, 1030};
        vecs[3] = '{1, 32'd2048,        1'b1, 0, 1'b1, 0,   22'h000000, 1030};
        vecs[4] = '{0, 32'h8000_0003,   1'b0, 2, 1'b1, 0,   22'h000000, 1600};

        fork
            monitorLoop();
        join_none

        repeat (3) @(negedge CLK);
        checkOutput("rst_sd_ack", 32'(sd_ack), 32'd0);
        checkOutput("rst_buff_addr", 32'(sd_buff_addr), 32'd0);
        checkOutput("rst_buff_dout", 32'(sd_buff_dout), 32'd0);
        checkOutput("rst_buff_wr", 32'(sd_buff_wr), 32'd0);
        checkOutput("rst_mem_rd", 32'(mem_rd), 32'd0);
        checkOutput("rst_mem_wr", 32'(mem_wr), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_oob", 32'(oob), 32'd0);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Single transfers from the vector table.
        for (int v = 0; v < 5; v++) begin
            mem_delay = vecs[v].delay;
            ops0 = hs_count;
            rd0  = mem_rd_cycles;
            wr0  = mem_wr_cycles;
            if (vecs[v].is_read) pushRead(vecs[v].exp_oob);
            applyStimulus(vecs[v].drive, vecs[v].lba, vecs[v].is_read, !vecs[v].is_read, ack_wait, total);
            checkOutput("ack_latency", 32'(ack_wait), 32'd2);
            checkOutput("cycle_budget", 32'(total <= vecs[v].max_cycles), 32'd1);
            checkOutput("oob_flag", 32'(oob), 32'(vecs[v].exp_oob));
            checkOutput("mem_ops", 32'(hs_count - ops0), 32'(vecs[v].exp_ops));
            checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
            if (vecs[v].exp_ops == 0) begin
                checkOutput("oob_no_mem_rd", 32'(mem_rd_cycles - rd0), 32'd0);
                checkOutput("oob_no_mem_wr", 32'(mem_wr_cycles - wr0), 32'd0);
            end else begin
                checkOutput("mem_base", 32'(hs_log[ops0]), 32'(vecs[v].exp_base));
                checkOutput("mem_last", 32'(hs_log[ops0 + 511]), 32'(vecs[v].exp_base + 22'd511));
                if (!vecs[v].is_read) checkBlockWrite(vecs[v].drive, vecs[v].exp_base);
            end
        end

        // Simultaneous reads on drives 1 and 3 after a drive 1 transfer
        // (pointer now 2): drive 3 must be served before drive 1.
        mem_delay = 0;
        pushRead(1'b0);
        applyStimulus(1, 32'd7, 1'b1, 1'b0, ack_wait, total);
        grant_q.delete();
        ops0 = hs_count;
        pushRead(1'b0);
        pushRead(1'b0);
        fork
            applyStimulus(3, 32'd12, 1'b1, 1'b0, aw3, t3);
            applyStimulus(1, 32'd13, 1'b1, 1'b0, aw1, t1);
        join
        checkOutput("rr_grants", 32'(grant_q.size()), 32'd2);
        checkOutput("rr_first", 32'(grant_q.size() > 0 ? grant_q[0] : -1), 32'd3);
        checkOutput("rr_second", 32'(grant_q.size() > 1 ? grant_q[1] : -1), 32'd1);
        checkOutput("rr_first_latency", 32'(aw3), 32'd2);
        checkOutput("rr_base3", 32'(hs_log[ops0]), 32'h301800);
        checkOutput("rr_base1", 32'(hs_log[ops0 + 512]), 32'h101A00);
        checkOutput("rr_sb_drained", 32'(sb_q.size()), 32'd0);

        // Read and write together on drive 0: read first, write after the
        // requester drops sd_rd only.
        mem_delay = 1;
        ops0 = hs_count;
        cyc  = 0;
        pushRead(1'b0);
        @(posedge CLK);
        #1;
        sd_lba[0] = 32'd9;
        sd_rd[0]  = 1'b1;
        sd_wr[0]  = 1'b1;
        waitAck(0, 1'b1, "prio_ack_rd", cyc);
        sd_rd[0] = 1'b0;
        waitAck(0, 1'b0, "prio_done_rd", cyc);
        checkOutput("prio_read_first", 32'(sb_q.size()), 32'd0);
        checkOutput("prio_read_ops", 32'(hs_count - ops0), 32'd512);
        checkOutput("prio_no_write_yet", 32'(mem_store.exists(22'h001200)), 32'd0);
        waitAck(0, 1'b1, "prio_ack_wr", cyc);
        sd_wr[0] = 1'b0;
        waitAck(0, 1'b0, "prio_done_wr", cyc);
        checkBlockWrite(0, 22'h001200);

        // Reset at byte 100 of a read, then a fresh read from offset 0.
        mem_delay = 0;
        pushRead(1'b0);
        s0  = strobes;
        cyc = 0;
        @(posedge CLK);
        #1;
        sd_lba[1] = 32'd20;
        sd_rd[1]  = 1'b1;
        while ((strobes - s0 < 100) && (cyc < BUDGET)) begin
            @(negedge CLK);
            cyc++;
        end
        checkOutput("rst_reach_byte100", 32'(strobes - s0 >= 100), 32'd1);
        RESET_N = 1'b0;
        #1;
        checkOutput("midrst_sd_ack", 32'(sd_ack), 32'd0);
        checkOutput("midrst_mem_rd", 32'(mem_rd), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_buff_wr", 32'(sd_buff_wr), 32'd0);
        checkOutput("midrst_oob", 32'(oob), 32'd0);
        sd_rd[1] = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        pushRead(1'b0);
        applyStimulus(1, 32'd20, 1'b1, 1'b0, ack_wait, total);
        checkOutput("restart_latency", 32'(ack_wait), 32'd2);
        checkOutput("restart_sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
